// File: rtl/axi_lite_dma_csr.sv
// rtl/axi_lite_dma_csr.sv - AXI4-Lite CSR bank for a multi-channel DMA; byte strobes enabled by AXI_LITE_CSR_WSTRB_EN
module axi_lite_dma_csr #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [ADDR_WIDTH-1:0]         AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [REG_WIDTH-1:0]          WDATA,
    input  logic [REG_WIDTH/8-1:0]        WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [ADDR_WIDTH-1:0]         ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [REG_WIDTH-1:0]          RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [NUM_CH-1:0]             ch_start,
    output logic [NUM_CH-1:0]             ch_irq_en,
    output logic [NUM_CH*REG_WIDTH-1:0]   ch_src,
    output logic [NUM_CH*REG_WIDTH-1:0]   ch_dst,
    output logic [NUM_CH*REG_WIDTH-1:0]   ch_len,
    input  logic [NUM_CH-1:0]             ch_busy,
    input  logic [NUM_CH-1:0]             ch_done,
    output logic                          irq
);
    localparam int STRB_W = REG_WIDTH / 8;
    localparam int CHW    = ADDR_WIDTH - 5;
    localparam logic [ADDR_WIDTH-1:0] IRQ_ADDR = ADDR_WIDTH'(NUM_CH * 32);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    // reg_sel is the word index inside a channel window: 0 CTRL .. 4 STATUS
    typedef struct packed {
        logic           hit_ch;
        logic           hit_irq;
        logic [CHW-1:0] ch;
        logic [2:0]     reg_sel;
    } dec_t;

    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        dec_t d;
        d         = '0;
        d.ch      = addr[ADDR_WIDTH-1:5];
        d.reg_sel = addr[4:2];
        if (addr[1:0] == 2'b00) begin
            if (addr == IRQ_ADDR)
                d.hit_irq = 1'b1;
            else if ((d.ch < CHW'(NUM_CH)) && (addr[4:2] <= 3'd4))
                d.hit_ch = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [REG_WIDTH-1:0] merge(input logic [REG_WIDTH-1:0] old_v,
                                                   input logic [REG_WIDTH-1:0] new_v,
                                                   input logic [STRB_W-1:0]    strb);
        logic [REG_WIDTH-1:0] m;
        m = old_v;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
        return m;
    endfunction

    wstate_t                r_wstate, w_wstate_nxt;
    rstate_t                r_rstate, w_rstate_nxt;
    logic                   r_init;
    logic                   r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [REG_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [1:0]             r_bresp, r_rresp;
    logic [REG_WIDTH-1:0]   r_rdata;
    logic [REG_WIDTH-1:0]   r_src [NUM_CH];
    logic [REG_WIDTH-1:0]   r_dst [NUM_CH];
    logic [REG_WIDTH-1:0]   r_len [NUM_CH];
    logic [NUM_CH-1:0]      r_irq_en, r_done, r_start;
    logic                   r_irq;

    logic                   w_aw_hs, w_w_hs, w_ar_hs;
    logic                   w_wr_fire, w_wr_ok;
    logic [ADDR_WIDTH-1:0]  w_waddr;
    logic [REG_WIDTH-1:0]   w_wdata;
    logic [STRB_W-1:0]      w_wstrb, w_wstrb_eff;
    dec_t                   w_wdec, w_rdec;
    logic [1:0]             w_bresp_nxt, w_rresp_nxt;
    logic [REG_WIDTH-1:0]   w_rdata_nxt;
    logic [NUM_CH-1:0]      w_w1c;

`ifdef AXI_LITE_CSR_WSTRB_EN
    assign w_wstrb_eff = w_wstrb;
`else
    logic w_unused_strb;
    assign w_unused_strb = ^w_wstrb;
    assign w_wstrb_eff   = '1;
`endif

    // Ready/valid are pure functions of state; r_init holds readies low for the first cycle after reset
    assign AWREADY = r_init & (r_wstate == W_IDLE) & ~r_aw_held;
    assign WREADY  = r_init & (r_wstate == W_IDLE) & ~r_w_held;
    assign BVALID  = (r_wstate == W_RESP);
    assign ARREADY = r_init & (r_rstate == R_IDLE);
    assign RVALID  = (r_rstate == R_DATA);
    assign BRESP   = r_bresp;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign ch_start  = r_start;
    assign ch_irq_en = r_irq_en;
    assign irq       = r_irq;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign ch_src[g*REG_WIDTH +: REG_WIDTH] = r_src[g];
        assign ch_dst[g*REG_WIDTH +: REG_WIDTH] = r_dst[g];
        assign ch_len[g*REG_WIDTH +: REG_WIDTH] = r_len[g];
    end

    // A write commits in the same cycle its second half arrives, so use live AW/W data when not yet held
    assign w_aw_hs   = AWVALID & AWREADY;
    assign w_w_hs    = WVALID & WREADY;
    assign w_ar_hs   = ARVALID & ARREADY;
    assign w_waddr   = r_aw_held ? r_awaddr : AWADDR;
    assign w_wdata   = r_w_held  ? r_wdata  : WDATA;
    assign w_wstrb   = r_w_held  ? r_wstrb  : WSTRB;
    assign w_wr_fire = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wdec    = decode(w_waddr);
    assign w_rdec    = decode(ARADDR);
    assign w_wr_ok   = w_wr_fire & w_wdec.hit_ch;
    assign w_bresp_nxt = w_wdec.hit_ch ? RESP_OKAY : (w_wdec.hit_irq ? RESP_SLVERR : RESP_DECERR);

    // Write FSM next state: leave idle once both halves are present, return after the B handshake
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_wr_fire) w_wstate_nxt = W_RESP;
            W_RESP:  if (BREADY)    w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state: one data beat per accepted address
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (RREADY)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Per-channel DONE clear requests from a successful STATUS write with bit1 set
    always_comb begin
        w_w1c = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (w_wr_ok && (w_wdec.ch == CHW'(c)) && (w_wdec.reg_sel == 3'd4))
                w_w1c[c] = w_wdata[1] & w_wstrb_eff[0];
    end

    // Read mux evaluated against current register values, so a same-cycle write is not visible
    always_comb begin
        w_rdata_nxt = '0;
        w_rresp_nxt = RESP_DECERR;
        if (w_rdec.hit_irq) begin
            w_rresp_nxt = RESP_OKAY;
            w_rdata_nxt[NUM_CH-1:0] = r_done & r_irq_en;
        end else if (w_rdec.hit_ch) begin
            w_rresp_nxt = RESP_OKAY;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_rdec.ch == CHW'(c)) begin
                    case (w_rdec.reg_sel)
                        3'd0: w_rdata_nxt[1] = r_irq_en[c];
                        3'd1: w_rdata_nxt    = r_src[c];
                        3'd2: w_rdata_nxt    = r_dst[c];
                        3'd3: w_rdata_nxt    = r_len[c];
                        3'd4: begin
                            w_rdata_nxt[0] = ch_busy[c];
                            w_rdata_nxt[1] = r_done[c];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // FSM state registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Channel capture, register file, sticky DONE and interrupt
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_init    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= '0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_irq_en  <= '0;
            r_done    <= '0;
            r_start   <= '0;
            r_irq     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_src[c] <= '0;
                r_dst[c] <= '0;
                r_len[c] <= '0;
            end
        end else begin
            r_init  <= 1'b1;
            r_start <= '0;
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_bresp_nxt;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= WDATA;
                    r_wstrb  <= WSTRB;
                end
            end
            if (w_ar_hs) begin
                r_rdata <= w_rdata_nxt;
                r_rresp <= w_rresp_nxt;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_ok && (w_wdec.ch == CHW'(c))) begin
                    case (w_wdec.reg_sel)
                        3'd0: if (w_wstrb_eff[0]) begin
                            r_irq_en[c] <= w_wdata[1];
                            r_start[c]  <= w_wdata[0];
                        end
                        3'd1: r_src[c] <= merge(r_src[c], w_wdata, w_wstrb_eff);
                        3'd2: r_dst[c] <= merge(r_dst[c], w_wdata, w_wstrb_eff);
                        3'd3: r_len[c] <= merge(r_len[c], w_wdata, w_wstrb_eff);
                        default: ;
                    endcase
                end
            end
            // a done pulse coinciding with a clear keeps DONE set
            r_done <= ch_done | (r_done & ~w_w1c);
            r_irq  <= |(r_done & r_irq_en);
        end
    end
endmodule

// File: tb/tb_axi_lite_dma_csr.sv
// tb/tb_axi_lite_dma_csr.sv - self-checking bench for axi_lite_dma_csr
module tb_axi_lite_dma_csr;
    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [11:0]  AWADDR, ARADDR;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [31:0]  WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [3:0]   ch_start, ch_irq_en, ch_busy, ch_done;
    logic [127:0] ch_src, ch_dst, ch_len;
    logic         irq;

    axi_lite_dma_csr dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ch_start(ch_start), .ch_irq_en(ch_irq_en),
        .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
        .ch_busy(ch_busy), .ch_done(ch_done), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int n_total = 0;
    int n_pass  = 0;
    logic [3:0] g_start_at_b, g_start_after;

    // reference model state
    logic [31:0] m_src [4];
    logic [31:0] m_dst [4];
    logic [31:0] m_len [4];
    logic [3:0]  m_ien, m_done;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, output logic [1:0] resp);
        bit aw_ok = 1'b0;
        bit w_ok  = 1'b0;
        int cyc   = 0;
        int lat   = 0;
        while (!(aw_ok && w_ok) && cyc < 50) begin
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = !aw_ok && (cyc >= awd);
            WVALID  = !w_ok && (cyc >= wd);
            if (AWVALID && AWREADY) aw_ok = 1'b1;
            if (WVALID && WREADY)   w_ok  = 1'b1;
            @(negedge ACLK);
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("write_handshake", {aw_ok, w_ok}, 2'b11);
        while (!BVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("write_latency", lat, 0);
        resp         = BRESP;
        g_start_at_b = ch_start;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        g_start_after = ch_start;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n   = 0;
        int lat = 0;
        ARADDR  = a;
        ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("read_arready", n, 0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        while (!RVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("read_latency", lat, 0);
        d    = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    // Behavioural register map: decode by plain address arithmetic, apply or read
    task automatic model_op(input bit wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] busy,
                            output logic [1:0] resp, output logic [31:0] rd, output logic [3:0] start);
        int ai  = int'(a);
        int ch  = ai / 32;
        int off = ai % 32;
        logic [31:0] m;
        resp  = 2'b11;
        rd    = '0;
        start = '0;
`ifdef AXI_LITE_CSR_WSTRB_EN
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
`else
        m = '1;
`endif
        if (ai % 4 != 0) begin
            resp = 2'b11;
        end else if (ai == 128) begin
            if (wr) resp = 2'b10;
            else begin
                resp = 2'b00;
                rd   = {28'b0, m_done & m_ien};
            end
        end else if (ai < 128 && off <= 16) begin
            resp = 2'b00;
            case (off)
                0: if (wr) begin
                       if (m[0]) begin
                           m_ien[ch]   = d[1];
                           start[ch]   = d[0];
                       end
                   end else rd = {30'b0, m_ien[ch], 1'b0};
                4:  if (wr) m_src[ch] = (m_src[ch] & ~m) | (d & m); else rd = m_src[ch];
                8:  if (wr) m_dst[ch] = (m_dst[ch] & ~m) | (d & m); else rd = m_dst[ch];
                12: if (wr) m_len[ch] = (m_len[ch] & ~m) | (d & m); else rd = m_len[ch];
                default: if (wr) begin
                             if (m[0] && d[1]) m_done[ch] = 1'b0;
                         end else rd = {30'b0, m_done[ch], busy[ch]};
            endcase
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [1:0]  resp, eresp;
        logic [31:0] rd, erd, exp_len, d;
        logic [3:0]  estart, s, busy, p;
        logic [11:0] a;
        bit          wr;

`ifdef AXI_LITE_CSR_WSTRB_EN
        exp_len = 32'h0000_5678;
`else
        exp_len = 32'h1234_5678;
`endif
        tbl.push_back('{1'b1, 12'h004, 32'h1111_2222, 4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 12'h004, 32'h0,         4'hF, 2'b00, 32'h1111_2222});
        tbl.push_back('{1'b1, 12'h00C, 32'h1234_5678, 4'h3, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 12'h00C, 32'h0,         4'hF, 2'b00, exp_len});
        tbl.push_back('{1'b1, 12'h068, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 12'h068, 32'h0,         4'hF, 2'b00, 32'hA5A5_A5A5});
        tbl.push_back('{1'b1, 12'h080, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
        tbl.push_back('{1'b0, 12'h080, 32'h0,         4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b1, 12'h014, 32'h0000_0001, 4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b0, 12'h084, 32'h0,         4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b0, 12'h006, 32'h0,         4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b1, 12'h006, 32'h7777_7777, 4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b0, 12'h014, 32'h0,         4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b1, 12'h0A0, 32'h1,         4'hF, 2'b11, 32'h0});
        tbl.push_back('{1'b0, 12'h010, 32'h0,         4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b1, 12'h020, 32'h0000_0002, 4'hF, 2'b00, 32'h0});
        tbl.push_back('{1'b0, 12'h020, 32'h0,         4'hF, 2'b00, 32'h2});
        tbl.push_back('{1'b0, 12'h004, 32'h0,         4'hF, 2'b00, 32'h1111_2222});

        ARESET = 1'b1;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        ch_busy = '0; ch_done = '0;
        repeat (3) @(negedge ACLK);

        check("rst_awready", AWREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_bvalid",  BVALID,  1'b0);
        check("rst_rvalid",  RVALID,  1'b0);
        check("rst_irq",     irq,     1'b0);
        check("rst_src",     ch_src,  128'h0);
        check("rst_start",   ch_start, 4'h0);
        ARESET = 1'b0;
        #1;
        check("rel_awready_low", AWREADY, 1'b0);
        @(negedge ACLK);
        check("rel_awready", AWREADY, 1'b1);
        check("rel_wready",  WREADY,  1'b1);
        check("rel_arready", ARREADY, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, resp);
                check($sformatf("tbl%0d_bresp", i), resp, tbl[i].resp);
            end else begin
                axi_read(tbl[i].addr, rd, resp);
                check($sformatf("tbl%0d_rresp", i), resp, tbl[i].resp);
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            end
        end

        // AW leads W by two cycles
        axi_write(12'h024, 32'hCAFE_BABE, 4'hF, 0, 2, resp);
        check("awfirst_bresp", resp, 2'b00);
        check("awfirst_src1", ch_src[63:32], 32'hCAFE_BABE);
        axi_read(12'h024, rd, resp);
        check("awfirst_rdata", rd, 32'hCAFE_BABE);
        check("awfirst_rresp", resp, 2'b00);
        // W leads AW
        axi_write(12'h028, 32'h0BAD_F00D, 4'hF, 3, 0, resp);
        check("wfirst_dst1", ch_dst[63:32], 32'h0BAD_F00D);

        // start pulse and irq enable
        axi_write(12'h040, 32'h3, 4'hF, 0, 0, resp);
        check("start_pulse", g_start_at_b, 4'b0100);
        check("start_gone",  g_start_after, 4'b0000);
        check("irq_en2", ch_irq_en[2], 1'b1);
        axi_read(12'h040, rd, resp);
        check("ctrl_read", rd, 32'h2);

        // sticky done, irq status, W1C
        ch_done = 4'b0100;
        @(negedge ACLK);
        ch_done = 4'b0000;
        axi_read(12'h050, rd, resp);
        check("done_status", rd, 32'h2);
        axi_read(12'h080, rd, resp);
        check("irq_status", rd, 32'h4);
        check("irq_high", irq, 1'b1);
        axi_write(12'h050, 32'h2, 4'hF, 0, 0, resp);
        check("w1c_bresp", resp, 2'b00);
        axi_read(12'h050, rd, resp);
        check("w1c_status", rd, 32'h0);
        check("irq_low", irq, 1'b0);

        // done pulse on the same edge as the W1C write
        AWADDR = 12'h050; WDATA = 32'h2; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; ch_done = 4'b0100;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ch_done = 4'b0000;
        check("sim_bvalid", BVALID, 1'b1);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        axi_read(12'h050, rd, resp);
        check("sim_done_kept", rd, 32'h2);
        check("sim_irq", irq, 1'b1);

        // live busy
        ch_busy = 4'b0010;
        axi_read(12'h030, rd, resp);
        check("busy_live", rd, 32'h1);
        ch_busy = 4'b0000;

        // BREADY held low
        AWADDR = 12'h008; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bhold_bvalid",  BVALID,  1'b1);
            check("bhold_bresp",   BRESP,   2'b00);
            check("bhold_awready", AWREADY, 1'b0);
            check("bhold_wready",  WREADY,  1'b0);
            @(negedge ACLK);
        end
        check("bhold_dst0", ch_dst[31:0], 32'hDEAD_BEEF);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bhold_release", BVALID, 1'b0);

        // RREADY held low
        ARADDR = 12'h008; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rhold_rvalid",  RVALID,  1'b1);
            check("rhold_rdata",   RDATA,   32'hDEAD_BEEF);
            check("rhold_rresp",   RRESP,   2'b00);
            check("rhold_arready", ARREADY, 1'b0);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("rhold_release", RVALID, 1'b0);

        // reset while a response is pending
        AWADDR = 12'h004; WDATA = 32'h55; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        check("mid_bvalid", BVALID, 1'b1);
        ARESET = 1'b1;
        #1;
        check("mid_rst_bvalid", BVALID, 1'b0);
        check("mid_rst_src", ch_src, 128'h0);
        check("mid_rst_dst", ch_dst, 128'h0);
        check("mid_rst_len", ch_len, 128'h0);
        check("mid_rst_ien", ch_irq_en, 4'h0);
        check("mid_rst_irq", irq, 1'b0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_bvalid", BVALID, 1'b0);
        check("post_rst_rvalid", RVALID, 1'b0);
        check("post_rst_awready", AWREADY, 1'b1);

        // randomized traffic against the model
        for (int c = 0; c < 4; c++) begin
            m_src[c] = '0; m_dst[c] = '0; m_len[c] = '0;
        end
        m_ien = '0; m_done = '0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = 4'($urandom);
                ch_done = p;
                @(negedge ACLK);
                ch_done = '0;
                m_done = m_done | p;
                @(negedge ACLK);
            end
            case ($urandom_range(0, 9))
                7:       a = 12'h080;
                8:       a = 12'($urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                9:       a = 12'(128 + $urandom_range(1, 20) * 4);
                default: a = 12'($urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4);
            endcase
            wr   = 1'($urandom_range(0, 1));
            d    = $urandom;
            s    = 4'($urandom);
            busy = 4'($urandom);
            ch_busy = busy;
            model_op(wr, a, d, s, busy, eresp, erd, estart);
            if (wr) begin
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
                check($sformatf("rnd%0d_bresp@%0h", it, a), resp, eresp);
                check($sformatf("rnd%0d_start@%0h", it, a), g_start_at_b, estart);
            end else begin
                axi_read(a, rd, resp);
                check($sformatf("rnd%0d_rresp@%0h", it, a), resp, eresp);
                check($sformatf("rnd%0d_rdata@%0h", it, a), rd, erd);
            end
            check($sformatf("rnd%0d_irq", it), irq, |(m_done & m_ien));
        end
        for (int c = 0; c < 4; c++) begin
            check($sformatf("end_src%0d", c), ch_src[c*32 +: 32], m_src[c]);
            check($sformatf("end_dst%0d", c), ch_dst[c*32 +: 32], m_dst[c]);
            check($sformatf("end_len%0d", c), ch_len[c*32 +: 32], m_len[c]);
        end
        check("end_ien", ch_irq_en, m_ien);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_lite_dma_csr.md
# axi_lite_dma_csr

Parametrised multi-channel AXI4-Lite control/status register bank for the DMA engine. Provides one register window per DMA channel (CTRL/SRC/DST/LEN/STATUS), a sticky done flag with write-1-to-clear semantics, and a global interrupt status register with a combined `irq` output. AW and W channels are accepted independently, in either order. Sits between the AXI-Lite interconnect and the per-channel DMA datapaths.

## Interface
- `REG_WIDTH`, 32: data/register width; a multiple of 8.
- `ADDR_WIDTH`, 12: AXI address width.
- `NUM_CH`, 4: DMA channel count, 1..32.
- `ACLK` in 1: clock.
- `ARESET` in 1: reset, asynchronous, active-high.
- `AWADDR` in ADDR_WIDTH; `AWVALID` in 1; `AWREADY` out 1: write address channel.
- `WDATA` in REG_WIDTH; `WSTRB` in REG_WIDTH/8; `WVALID` in 1; `WREADY` out 1: write data channel.
- `BRESP` out 2; `BVALID` out 1; `BREADY` in 1: write response channel.
- `ARADDR` in ADDR_WIDTH; `ARVALID` in 1; `ARREADY` out 1: read address channel.
- `RDATA` out REG_WIDTH; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1: read data channel.
- `ch_start` out NUM_CH: one-cycle start pulse per channel.
- `ch_irq_en` out NUM_CH: per-channel interrupt enable.
- `ch_src`, `ch_dst`, `ch_len` out NUM_CH*REG_WIDTH: flattened; channel c occupies bits [c*REG_WIDTH +: REG_WIDTH].
- `ch_busy` in NUM_CH: live busy level from each channel.
- `ch_done` in NUM_CH: one-cycle done pulse from each channel.
- `irq` out 1: OR over all channels of done_sticky & irq_en.

## Operation
- Channel c base address = c*0x20. Offsets within the window:
  - 0x00 CTRL: bit0 START (write 1 -> pulse; reads 0), bit1 IRQ_EN (R/W).
  - 0x04 SRC, 0x08 DST, 0x0C LEN: R/W.
  - 0x10 STATUS: bit0 BUSY (live `ch_busy`), bit1 DONE (sticky). Writing 1 to bit1 clears DONE; all other bits are ignored; response is OKAY.
  - 0x14–0x1C: unmapped.
- NUM_CH*0x20: IRQ_STATUS. Bit c = done_sticky[c] & irq_en[c]. Read-only.
- Responses:
  - OKAY 2'b00 on success.
  - SLVERR 2'b10 on a write to IRQ_STATUS.
  - DECERR 2'b11 on any unmapped or unaligned address (addr[1:0] != 0). On DECERR, reads return RDATA = 0.
- An errored write leaves all state unchanged.
- Write FSM:
  - W_IDLE: AW and W are captured independently. AWREADY = !aw_held; WREADY = !w_held.
  - When both are held, move to W_RESP on the next edge. Register update, `ch_start` pulse and BVALID all occur on that edge.
  - W_RESP: BVALID = 1 until BREADY is sampled high, then return to W_IDLE with both held flags cleared. AWREADY and WREADY are 0 in W_RESP.
- Read FSM:
  - R_IDLE: ARREADY = 1. An AR handshake moves to R_DATA.
  - R_DATA: RVALID = 1, with RDATA/RRESP registered at entry and stable until the RREADY handshake. ARREADY = 0.
- Done handling:
  - A `ch_done` pulse sets done_sticky[c].
  - A simultaneous `ch_done` pulse and W1C write: set wins.
  - DONE is set regardless of IRQ_EN; `irq` is gated by IRQ_EN.
- Simultaneous read and write to the same register: the read returns the pre-write value.

## Timing
- Reset (async assert; release synchronised by the system):
  - All outputs 0; all registers 0; both FSMs idle; held flags clear.
  - AWREADY/WREADY/ARREADY return to 1 one cycle after release.
- Write latency: BVALID rises one cycle after the cycle in which the later of the AW/W handshakes completes.
- Minimum write cycle: 2 cycles (AW+W together, then BVALID with BREADY=1).
- `ch_start[c]` is high exactly one cycle, the same cycle BVALID first rises.
- Register outputs (`ch_src` etc.) update on the BVALID-rise edge.
- Read latency: RVALID rises one cycle after the AR handshake. Back-to-back reads can complete every 2 cycles.
- `irq` is registered and follows done_sticky/irq_en changes with 1-cycle latency.
- Reset mid-transaction aborts the transaction; no B or R beat is issued after reset.

## Configuration
- `AXI_LITE_CSR_WSTRB_EN` defined: WSTRB is honoured byte-wise on SRC/DST/LEN/CTRL. STATUS W1C uses byte 0 only.
- Undefined: WSTRB is ignored and every write is full-word.

## Test plan
- NUM_CH=4. Write 0x24 = 0xCAFEBABE with AW two cycles before W, then read 0x24 -> BRESP 00; `ch_src[63:32]` = 0xCAFEBABE; RDATA 0xCAFEBABE; RRESP 00.
- Write 0x40 = 0x3 -> `ch_start[2]` high for exactly one cycle; `ch_irq_en[2]` = 1; read 0x40 -> 0x2.
- Pulse `ch_done[2]`, then read 0x50 and 0x80 -> 0x2 and 0x4; `irq` = 1. Write 0x50 = 0x2 -> read 0x50 = 0; `irq` = 0. Repeat with the `ch_done` pulse in the same cycle as the W1C write -> DONE remains 1.
- Write 0x80 -> BRESP 10, state unchanged. Write 0x14 -> BRESP 11. Read 0x84 -> RRESP 11, RDATA 0. Read 0x06 -> RRESP 11.
- With `AXI_LITE_CSR_WSTRB_EN` defined: write 0x0C = 0x12345678 with WSTRB 4'h3 over a reset LEN -> read returns 0x00005678. Without the macro -> read returns 0x12345678.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data remain stable and AWREADY/ARREADY stay 0. Assert ARESET mid-W_RESP -> BVALID 0 immediately and all registers 0.
